// File: rtl/crystal_pkg.sv
// crystal_pkg: shared bank geometry, port-B state encoding and select decode helper.
package crystal_pkg;
  localparam int BRAMS = 9;
  localparam int SEL_W = 4;
  localparam int PB_AW = 11;
  localparam int PB_DW = 64;
  localparam int LEN_W = 12;
  localparam int PB_DEPTH = 1 << PB_AW;
  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_RD_DRAIN, ST_WR, ST_DONE} portb_state_t;
  function automatic logic [BRAMS-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return BRAMS'(1) << s;
  endfunction
endpackage

// File: rtl/portb_skid_fifo.sv
// portb_skid_fifo: 2-entry fall-through skid buffer; an empty buffer passes input straight to output.
module portb_skid_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q, push, rel;
  logic [1:0]   cnt_q, cnt_d;
  always_comb begin
    out_valid_o = cnt_q != 2'd0 || in_valid_i;
    out_data_o  = cnt_q != 2'd0 ? mem_q[rp_q] : in_data_i;
    in_ready_o  = cnt_q != 2'd2;
    push        = in_valid_i && in_ready_o && !(cnt_q == 2'd0 && out_ready_i);
    rel         = out_ready_i && cnt_q != 2'd0;
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, rel};
  end
  assign count_o = cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wp_q <= ~wp_q;
      if (rel) rp_q <= ~rp_q;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_data_i;
  end
endmodule

// File: rtl/crystal_portb_ctrl.sv
// crystal_portb_ctrl: sequences the bank's shared port B for single-BRAM read/write bursts,
// exposing read data and taking write data as valid/ready streams.
module crystal_portb_ctrl
  import crystal_pkg::*;
(
  input  logic                   fmc_clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [SEL_W-1:0]       cmd_sel,
  input  logic [PB_AW-1:0]       cmd_addr,
  input  logic [LEN_W-1:0]       cmd_len,
  output logic [BRAMS-1:0]       enb,
  output logic                   web,
  output logic [PB_AW-1:0]       addrb,
  output logic [PB_DW-1:0]       dinb,
  input  logic [BRAMS*PB_DW-1:0] doutb,
  output logic [PB_DW-1:0]       rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   rd_last,
  input  logic [PB_DW-1:0]       wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  portb_state_t     state_q;
  logic [SEL_W-1:0] sel_q;
  logic [PB_AW-1:0] cur_q, addrb_q;
  logic [LEN_W-1:0] rem_q;
  logic [BRAMS-1:0] enb_q;
  logic [PB_DW-1:0] dinb_q;
  logic             web_q, rs_q, rs_last_q, dv_q, dv_last_q;
  logic             cmd_ready_q, wr_ready_q, busy_q, done_q, err_q;
  logic             cmd_fire, cmd_bad, rd_pop, issue, last_word;
  logic             fifo_valid, fifo_in_ready;
  logic [PB_DW:0]   fifo_data;
  logic [1:0]       fifo_cnt;
  logic [2:0]       occ;
  logic [PB_DW-1:0] slices [BRAMS];
  for (genvar i = 0; i < BRAMS; i++) begin : g_slice
    assign slices[i] = doutb[PB_DW*i +: PB_DW];
  end
  // occ is buffer occupancy after this edge; a read issued now lands behind the one already on the port
  always_comb begin
    cmd_fire  = cmd_valid && cmd_ready_q;
    cmd_bad   = int'(cmd_sel) >= BRAMS || cmd_len == '0 || int'(cmd_addr) + int'(cmd_len) > PB_DEPTH;
    rd_pop    = fifo_valid && rd_ready;
    occ       = {1'b0, fifo_cnt} + {2'b0, dv_q} + {2'b0, rs_q} - {2'b0, rd_pop};
    issue     = state_q == ST_RD && occ < 3'd2 && fifo_in_ready;
    last_word = rem_q == LEN_W'(1);
  end
  portb_skid_fifo #(.W(PB_DW + 1)) u_fifo (
    .clk         (fmc_clk),
    .rst         (rst),
    .in_valid_i  (dv_q),
    .in_data_i   ({dv_last_q, slices[sel_q]}),
    .in_ready_o  (fifo_in_ready),
    .out_valid_o (fifo_valid),
    .out_data_o  (fifo_data),
    .out_ready_i (rd_ready),
    .count_o     (fifo_cnt)
  );
  always_ff @(posedge fmc_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      cur_q       <= '0;
      rem_q       <= '0;
      enb_q       <= '0;
      web_q       <= 1'b0;
      addrb_q     <= '0;
      dinb_q      <= '0;
      rs_q        <= 1'b0;
      rs_last_q   <= 1'b0;
      dv_q        <= 1'b0;
      dv_last_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      enb_q     <= '0;
      web_q     <= 1'b0;
      rs_q      <= 1'b0;
      rs_last_q <= 1'b0;
      err_q     <= 1'b0;
      dv_q      <= rs_q;
      dv_last_q <= rs_last_q;
      case (state_q)
        ST_IDLE: if (cmd_fire) begin
          if (cmd_bad) err_q <= 1'b1;
          else begin
            sel_q       <= cmd_sel;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_wr) begin
              cur_q      <= cmd_addr;
              rem_q      <= cmd_len;
              wr_ready_q <= 1'b1;
              state_q    <= ST_WR;
            end else begin
              enb_q     <= sel_onehot(cmd_sel);
              addrb_q   <= cmd_addr;
              rs_q      <= 1'b1;
              rs_last_q <= cmd_len == LEN_W'(1);
              cur_q     <= cmd_addr + PB_AW'(1);
              rem_q     <= cmd_len - LEN_W'(1);
              state_q   <= cmd_len == LEN_W'(1) ? ST_RD_DRAIN : ST_RD;
            end
          end
        end
        ST_RD: if (issue) begin
          enb_q     <= sel_onehot(sel_q);
          addrb_q   <= cur_q;
          rs_q      <= 1'b1;
          rs_last_q <= last_word;
          cur_q     <= cur_q + PB_AW'(1);
          rem_q     <= rem_q - LEN_W'(1);
          if (last_word) state_q <= ST_RD_DRAIN;
        end
        ST_RD_DRAIN: if (rd_pop && rd_last) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_WR: if (wr_valid && wr_ready_q) begin
          enb_q   <= sel_onehot(sel_q);
          web_q   <= 1'b1;
          addrb_q <= cur_q;
          dinb_q  <= wr_data;
          cur_q   <= cur_q + PB_AW'(1);
          rem_q   <= rem_q - LEN_W'(1);
          if (last_word) begin
            wr_ready_q <= 1'b0;
            state_q    <= ST_DONE;
          end
        end
        // a write enters here on its final strobe cycle, so done waits one extra cycle
        ST_DONE: if (done_q) begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end else done_q <= 1'b1;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign enb       = enb_q;
  assign web       = web_q;
  assign addrb     = addrb_q;
  assign dinb      = dinb_q;
  assign rd_data   = fifo_data[PB_DW-1:0];
  assign rd_valid  = fifo_valid;
  assign rd_last   = fifo_valid && fifo_data[PB_DW];
  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_crystal_portb_ctrl.sv
// tb_crystal_portb_ctrl: random burst jobs against a BRAM bank model, with a reference memory
// and scoreboard queues checked by a free-running monitor.
module tb_crystal_portb_ctrl;
  import crystal_pkg::*;
  logic                   fmc_clk = 1'b0, rst = 1'b0;
  logic                   cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [SEL_W-1:0]       cmd_sel = '0;
  logic [PB_AW-1:0]       cmd_addr = '0;
  logic [LEN_W-1:0]       cmd_len = '0;
  logic [BRAMS-1:0]       enb;
  logic                   web;
  logic [PB_AW-1:0]       addrb;
  logic [PB_DW-1:0]       dinb, rd_data;
  logic [PB_DW-1:0]       wr_data = '0;
  logic [BRAMS*PB_DW-1:0] doutb = '0;
  logic                   rd_valid, rd_last, wr_ready, busy, done, err;
  logic                   rd_ready = 1'b1, wr_valid = 1'b0;
  always #5 fmc_clk = ~fmc_clk;

  crystal_portb_ctrl dut (
    .fmc_clk(fmc_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .enb(enb), .web(web), .addrb(addrb),
    .dinb(dinb), .doutb(doutb), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_last(rd_last), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .busy(busy),
    .done(done), .err(err)
  );

  int vectors = 0, miscompares = 0, cyc = 0, rd_mode = 0, rcyc = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic fail(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endtask

  function automatic logic [PB_DW-1:0] pat(input int i, input int a);
    return {8'hA5, 8'(i), 48'(a)};
  endfunction

  // BRAM bank model: 1-cycle read latency, contents seeded on the first clock
  logic [PB_DW-1:0] bram [BRAMS][PB_DEPTH];
  logic [PB_DW-1:0] ref_mem [BRAMS][PB_DEPTH];
  bit loaded = 1'b0;
  always @(posedge fmc_clk) begin
    cyc <= cyc + 1;
    if (!loaded) begin
      for (int i = 0; i < BRAMS; i++)
        for (int a = 0; a < PB_DEPTH; a++) bram[i][a] <= pat(i, a);
      loaded <= 1'b1;
    end else
      for (int i = 0; i < BRAMS; i++)
        if (enb[i]) begin
          if (web) bram[i][addrb] <= dinb;
          else doutb[PB_DW*i +: PB_DW] <= bram[i][addrb];
        end
  end

  always @(posedge fmc_clk) begin
    #1;
    rcyc++;
    rd_ready = rd_mode == 0 ? 1'b1 :
               rd_mode == 1 ? (rcyc % 2 == 0 && !(rcyc % 16 >= 4 && rcyc % 16 < 9)) :
               1'($urandom_range(0, 1));
  end

  logic [PB_DW:0]         exp_rd [$];
  logic [PB_AW+PB_DW-1:0] exp_wr [$];
  int exp_sel = 0, done_cnt = 0, done_cyc = -1, enb_cnt = 0, first_enb = -1;
  int last_strobe = -1, last_pop = -1, pops = 0;
  bit job_active = 1'b0, cur_wr = 1'b0, hold = 1'b0;
  logic [PB_DW:0] hold_val;

  always @(negedge fmc_clk) begin
    if (rst) hold = 1'b0;
    else begin
      if (hold) chk("rd_hold", {rd_valid, rd_last, rd_data}, {1'b1, hold_val});
      hold = rd_valid && !rd_ready;
      hold_val = {rd_last, rd_data};
      if (rd_valid) chk("fifo_count_le2", dut.u_fifo.count_o <= 2'd2, 1);
      if (rd_valid && rd_ready) begin
        pops++;
        if (exp_rd.size() == 0) fail("rd_extra", {rd_last, rd_data}, 0);
        else chk("rd_word", {rd_last, rd_data}, exp_rd.pop_front());
        if (rd_last) last_pop = cyc;
      end
      if (enb == '0 && web) fail("web_idle", web, 0);
      if (enb != '0) begin
        enb_cnt++;
        if (first_enb < 0) first_enb = cyc;
        chk("enb_onehot", enb, job_active ? (9'(1) << exp_sel) : 9'(0));
        if (web) begin
          last_strobe = cyc;
          if (exp_wr.size() == 0) fail("wr_extra", {addrb, dinb}, 0);
          else chk("wr_strobe", {addrb, dinb}, exp_wr.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_after", cyc, (cur_wr ? last_strobe : last_pop) + 1);
      end
    end
  end

  task automatic job(input bit wr, input int sel, input int addr, input int len, input bit wait_done);
    bit ok;
    int t, n, idx, d0, e0;
    logic [PB_DW-1:0] wd [$];
    logic [PB_DW-1:0] d;
    ok = sel < BRAMS && len > 0 && addr + len <= PB_DEPTH;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge fmc_clk); #1; n++; end
    if (n == 50) fail("cmd_ready_wait", 0, 1);
    if (ok) begin
      exp_sel = sel;
      cur_wr = wr;
      job_active = 1'b1;
      for (int k = 0; k < len; k++)
        if (wr) begin
          d = {$urandom, $urandom};
          wd.push_back(d);
          exp_wr.push_back({PB_AW'(addr + k), d});
          ref_mem[sel][addr+k] = d;
        end else exp_rd.push_back({k == len - 1, ref_mem[sel][addr+k]});
    end
    cmd_valid = 1'b1; cmd_wr = wr; cmd_sel = SEL_W'(sel); cmd_addr = PB_AW'(addr); cmd_len = LEN_W'(len);
    first_enb = -1; d0 = done_cnt; e0 = enb_cnt;
    @(negedge fmc_clk);
    t = cyc;
    chk("cmd_ready", cmd_ready, 1);
    @(posedge fmc_clk); #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      @(negedge fmc_clk);
      chk("err_pulse", err, 1);
      chk("cmd_ready_rej", cmd_ready, 1);
      @(negedge fmc_clk);
      chk("err_once", err, 0);
      repeat (3) @(negedge fmc_clk);
      chk("rej_no_enb", enb_cnt, e0);
      chk("rej_no_done", done_cnt, d0);
      @(posedge fmc_clk); #1;
      return;
    end
    if (wr) begin
      idx = 0; n = 0;
      while (idx < len && n < 1000) begin
        wr_valid = $urandom_range(0, 2) != 0;
        wr_data = wd[idx];
        @(negedge fmc_clk);
        if (n == 0) chk("wr_ready_t1", wr_ready, 1);
        if (wr_valid && wr_ready) idx++;
        @(posedge fmc_clk); #1;
        n++;
      end
      wr_valid = 1'b0;
    end
    if (!wait_done) return;
    n = 0;
    while (done_cnt == d0 && n < 500) begin @(negedge fmc_clk); n++; end
    chk("done_seen", done_cnt, d0 + 1);
    if (!wr && rd_mode == 0) begin
      chk("first_enb", first_enb, t + 1);
      chk("done_time", done_cyc, t + 2 + len);
    end
    chk("rd_all_delivered", exp_rd.size(), 0);
    chk("wr_all_strobed", exp_wr.size(), 0);
    job_active = 1'b0;
    @(posedge fmc_clk); #1;
  endtask

  initial begin
    int n, d0, p0, sel, len, addr;
    bit wr;
    for (int i = 0; i < BRAMS; i++)
      for (int a = 0; a < PB_DEPTH; a++) ref_mem[i][a] = pat(i, a);
    #1 rst = 1'b1;
    #1 chk("reset_values", {cmd_ready, enb, web, addrb, dinb, rd_valid, rd_last, wr_ready, busy, done, err}, {1'b1, 91'd0});
    repeat (3) @(posedge fmc_clk);
    @(negedge fmc_clk) rst = 1'b0;
    @(posedge fmc_clk); #1;
    rd_mode = 0; job(1'b0, 3, 'h100, 8, 1'b1);
    rd_mode = 1; job(1'b0, 3, 'h100, 8, 1'b1);
    rd_mode = 0; job(1'b1, 8, 'h7F8, 8, 1'b1);
    rd_mode = 2; job(1'b0, 8, 'h7F8, 8, 1'b1);
    rd_mode = 0;
    job(1'b0, 0, 'h7FF, 2, 1'b1);
    job(1'b1, 9, 0, 4, 1'b1);
    job(1'b0, 0, 0, 0, 1'b1);
    job(1'b1, 5, 'h7FF, 2, 1'b1);
    job(1'b0, 0, 'h7FF, 1, 1'b1);
    job(1'b1, 1, 0, 1, 1'b1);
    job(1'b0, 1, 0, 1, 1'b1);
    repeat (24) begin
      rd_mode = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      len = $urandom_range(0, 12);
      addr = $urandom_range(0, 3) == 0 ? PB_DEPTH - $urandom_range(1, 12) : $urandom_range(0, PB_DEPTH - 1);
      job(wr, sel, addr, len, 1'b1);
    end
    rd_mode = 0;
    p0 = pops;
    job(1'b0, 2, 'h40, 8, 1'b0);
    n = 0;
    while (pops < p0 + 3 && n < 50) begin @(negedge fmc_clk); n++; end
    if (n == 50) fail("rst_wait_pops", pops, p0 + 3);
    #2 rst = 1'b1;
    #1 chk("rst_midjob", {cmd_ready, enb, web, addrb, dinb, rd_valid, rd_last, wr_ready, busy, done, err}, {1'b1, 91'd0});
    exp_rd.delete();
    job_active = 1'b0;
    d0 = done_cnt;
    repeat (3) @(posedge fmc_clk);
    @(negedge fmc_clk) rst = 1'b0;
    repeat (5) @(negedge fmc_clk);
    chk("rst_no_done", done_cnt, d0);
    chk("rst_idle", {busy, cmd_ready}, 2'b01);
    @(posedge fmc_clk); #1;
    job(1'b0, 2, 'h40, 8, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
